// File: rtl/miniled_stream_monitor.sv
`default_nettype none
// ============================================================================
// Module      : miniled_stream_monitor
// Description : Receive-side loopback monitor for the MiniLED driver-chip
//               serial interface. Samples the LE/DCLK/SDI/GCLK/scan pin
//               copies on the system clock and decodes them back into
//               grayscale words, frame-start events and config writes.
//
// Ports
//   I_clk, I_rst     system clock, synchronous active-high reset
//   I_le, I_dclk,    pin copies exactly as driven toward the LED board
//   I_sdi, I_gclk,
//   I_scan[3:0]      {scan4,scan3,scan2,scan1}
//   O_word_valid     one-cycle pulse, O_word/O_word_idx/O_scan_idx valid
//   O_word           decoded grayscale word (MSB first on the wire)
//   O_word_idx       word index since the last frame start, saturating
//   O_scan_idx       encoded active scan line at the data latch
//   O_frame_start    one-cycle pulse on a vsync command
//   O_gclk_cnt       GCLK rising edges counted in the previous frame
//   O_cfg_valid      one-cycle pulse on a config-write command
//   O_cfg_word       shift register contents at the config latch
//   O_err_bitcnt     sticky: data latch with a bit count other than WORD_W
//   O_err_scan       sticky: scan lines not one-hot at a data latch
//
// Revision    : 1.0 - initial release
// ============================================================================
module miniled_stream_monitor #(
    parameter int WORD_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_le,
    input  logic              I_dclk,
    input  logic              I_sdi,
    input  logic              I_gclk,
    input  logic [3:0]        I_scan,
    output logic              O_word_valid,
    output logic [WORD_W-1:0] O_word,
    output logic [7:0]        O_word_idx,
    output logic [1:0]        O_scan_idx,
    output logic              O_frame_start,
    output logic [15:0]       O_gclk_cnt,
    output logic              O_cfg_valid,
    output logic [WORD_W-1:0] O_cfg_word,
    output logic              O_err_bitcnt,
    output logic              O_err_scan
);

    // Pin bundle layout inside the synchroniser chain
    localparam int PIN_W  = 8;
    localparam int P_LE   = 0;
    localparam int P_DCLK = 1;
    localparam int P_SDI  = 2;
    localparam int P_GCLK = 3;
    localparam int P_SCAN = 4;

    localparam logic [1:0]  CMD_NONE  = 2'd0;
    localparam logic [1:0]  CMD_DATA  = 2'd1;
    localparam logic [1:0]  CMD_VSYNC = 2'd2;
    localparam logic [1:0]  CMD_CFG   = 2'd3;

    localparam logic [4:0]  BIT_CNT_MAX  = 5'd31;
    localparam logic [2:0]  LE_CNT_MAX   = 3'd7;
    localparam logic [7:0]  WORD_CNT_MAX = 8'd255;
    localparam logic [15:0] GCLK_MAX     = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Stage index SYNC_STAGES is the extra delay register used for edges
    logic [SYNC_STAGES:0][PIN_W-1:0] sync_q;
    logic [PIN_W-1:0]                w_pins;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q;
    logic [4:0]          bit_cnt_q;
    logic [2:0]          le_cnt_q;
    logic [7:0]          word_cnt_q;
    logic [15:0]         gclk_acc_q;

    // Command captured at the LE fall, emitted while in LATCH
    logic [1:0]          pend_cmd_q;
    logic [WORD_W-1:0]   pend_data_q;
    logic                pend_bit_ok_q;
    logic [3:0]          pend_scan_q;
    logic [15:0]         pend_gclk_q;

    logic                w_dclk_rise;
    logic                w_le_fall;
    logic                w_gclk_rise;
    logic                w_sdi;
    logic                w_le_lvl;
    logic [3:0]          w_scan;
    logic [WORD_W-1:0]   w_shreg_upd;
    logic [4:0]          w_bit_cnt_upd;
    logic [2:0]          w_le_cnt_upd;
    logic [1:0]          w_cmd;
    logic [1:0]          w_scan_enc;
    logic                w_scan_ok;

    assign w_pins = {I_scan, I_gclk, I_sdi, I_dclk, I_le};

    assign w_dclk_rise = sync_q[SYNC_STAGES-1][P_DCLK] & ~sync_q[SYNC_STAGES][P_DCLK];
    assign w_gclk_rise = sync_q[SYNC_STAGES-1][P_GCLK] & ~sync_q[SYNC_STAGES][P_GCLK];
    assign w_le_fall   = sync_q[SYNC_STAGES][P_LE]     & ~sync_q[SYNC_STAGES-1][P_LE];
    assign w_sdi       = sync_q[SYNC_STAGES][P_SDI];
    assign w_le_lvl    = sync_q[SYNC_STAGES][P_LE];
    assign w_scan      = sync_q[SYNC_STAGES][P_SCAN +: 4];

    // Values after this cycle's DCLK rise; a coincident LE fall decodes these
    always_comb begin
        w_shreg_upd   = shreg_q;
        w_bit_cnt_upd = bit_cnt_q;
        w_le_cnt_upd  = le_cnt_q;
        if (w_dclk_rise) begin
            w_shreg_upd = {shreg_q[WORD_W-2:0], w_sdi};
            if (bit_cnt_q != BIT_CNT_MAX) begin
                w_bit_cnt_upd = bit_cnt_q + 5'd1;
            end
            if (w_le_lvl && (le_cnt_q != LE_CNT_MAX)) begin
                w_le_cnt_upd = le_cnt_q + 3'd1;
            end
        end
    end

    // Command decode from the number of DCLK rises seen with LE high
    always_comb begin
        w_cmd = CMD_NONE;
        if (w_le_fall) begin
            if (w_le_cnt_upd == 3'd0) begin
                w_cmd = CMD_NONE;
            end else if (w_le_cnt_upd == 3'd1) begin
                w_cmd = CMD_DATA;
            end else if (w_le_cnt_upd <= 3'd3) begin
                w_cmd = CMD_VSYNC;
            end else begin
                w_cmd = CMD_CFG;
            end
        end
    end

    always_comb begin
        w_scan_ok  = 1'b1;
        w_scan_enc = 2'd0;
        case (pend_scan_q)
            4'b0001: w_scan_enc = 2'd0;
            4'b0010: w_scan_enc = 2'd1;
            4'b0100: w_scan_enc = 2'd2;
            4'b1000: w_scan_enc = 2'd3;
            default: w_scan_ok  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A DCLK rise coincident with the LE fall can already form a command
                if (w_cmd != CMD_NONE) begin
                    state_d = ST_LATCH;
                end else if (w_dclk_rise) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_le_fall) begin
                    state_d = (w_cmd != CMD_NONE) ? ST_LATCH : ST_IDLE;
                end
            end
            ST_LATCH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            sync_q        <= '0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            le_cnt_q      <= '0;
            word_cnt_q    <= '0;
            gclk_acc_q    <= '0;
            pend_cmd_q    <= CMD_NONE;
            pend_data_q   <= '0;
            pend_bit_ok_q <= 1'b0;
            pend_scan_q   <= '0;
            pend_gclk_q   <= '0;
            O_word_valid  <= 1'b0;
            O_word        <= '0;
            O_word_idx    <= '0;
            O_scan_idx    <= '0;
            O_frame_start <= 1'b0;
            O_gclk_cnt    <= '0;
            O_cfg_valid   <= 1'b0;
            O_cfg_word    <= '0;
            O_err_bitcnt  <= 1'b0;
            O_err_scan    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-1:0], w_pins};
            shreg_q <= w_shreg_upd;

            if (w_le_fall) begin
                bit_cnt_q <= '0;
                le_cnt_q  <= '0;
            end else begin
                bit_cnt_q <= w_bit_cnt_upd;
                le_cnt_q  <= w_le_cnt_upd;
            end

            // A GCLK edge coincident with vsync belongs to the new frame
            if (w_cmd == CMD_VSYNC) begin
                gclk_acc_q <= w_gclk_rise ? 16'd1 : 16'd0;
            end else if (w_gclk_rise && (gclk_acc_q != GCLK_MAX)) begin
                gclk_acc_q <= gclk_acc_q + 16'd1;
            end

            if (w_cmd != CMD_NONE) begin
                pend_cmd_q    <= w_cmd;
                pend_data_q   <= w_shreg_upd;
                pend_bit_ok_q <= (w_bit_cnt_upd == 5'(WORD_W));
                pend_scan_q   <= w_scan;
                pend_gclk_q   <= gclk_acc_q;
            end

            O_word_valid  <= 1'b0;
            O_frame_start <= 1'b0;
            O_cfg_valid   <= 1'b0;

            if (state_q == ST_LATCH) begin
                case (pend_cmd_q)
                    CMD_DATA: begin
                        O_word_valid <= 1'b1;
                        O_word       <= pend_data_q;
                        O_word_idx   <= word_cnt_q;
                        O_scan_idx   <= w_scan_ok ? w_scan_enc : 2'd0;
                        if (word_cnt_q != WORD_CNT_MAX) begin
                            word_cnt_q <= word_cnt_q + 8'd1;
                        end
                        if (!pend_bit_ok_q) begin
                            O_err_bitcnt <= 1'b1;
                        end
                        if (!w_scan_ok) begin
                            O_err_scan <= 1'b1;
                        end
                    end
                    CMD_VSYNC: begin
                        O_frame_start <= 1'b1;
                        O_gclk_cnt    <= pend_gclk_q;
                        word_cnt_q    <= '0;
                    end
                    CMD_CFG: begin
                        O_cfg_valid <= 1'b1;
                        O_cfg_word  <= pend_data_q;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/miniled_stream_monitor.md
# miniled_stream_monitor

Receive-side monitor for the MiniLED driver-chip serial interface. It samples LE/DCLK/SDI/GCLK/scan1-4, exactly as driven toward the LED board, and decodes them back into grayscale words, frame-start events and config writes. It is used as an on-chip loopback checker in the MiniLED top, on the 50 MHz system clock, so that a logic analyser or UART dump can compare decoded words against the backlight values written by the frame writer.

## Interface
Parameters:
- WORD_W, 16, bits per grayscale word
- SYNC_STAGES, 2, input synchroniser depth (fixed at 2 for the timing below)

Ports:
- I_clk  in  1  system clock, 50 MHz
- I_rst  in  1  reset, synchronous, active-high
- I_le  in  1  LE pin copy
- I_dclk  in  1  DCLK pin copy
- I_sdi  in  1  SDI pin copy
- I_gclk  in  1  GCLK pin copy
- I_scan  in  4  {scan4,scan3,scan2,scan1}
- O_word_valid  out  1  one-cycle pulse: O_word is valid
- O_word  out  16  decoded grayscale word, MSB first on wire
- O_word_idx  out  8  word index since last frame start, saturates at 255
- O_scan_idx  out  2  encoded active scan line when the word latched
- O_frame_start  out  1  one-cycle pulse on a vsync command
- O_gclk_cnt  out  16  GCLK rising edges in the previous frame
- O_cfg_valid  out  1  one-cycle pulse on a config-write command
- O_cfg_word  out  16  shift register contents at the config latch
- O_err_bitcnt  out  1  sticky: a data latch saw a bit count other than 16
- O_err_scan  out  1  sticky: the scan lines were not one-hot at a data latch

## Operation
- All five pin inputs (LE, DCLK, SDI, GCLK, scan) pass through a 2-FF synchroniser. Edges are detected between sync stage 2 and a third delay register.
- On every DCLK rising edge:
  - SDI (stage-3 value) shifts into a 16-bit shift register, LSB in.
  - bit_cnt (5 bits, saturating at 31) increments.
  - If LE is high, le_cnt (3 bits, saturating at 7) increments.
- On every LE falling edge, the command is decoded from le_cnt:
  - le_cnt==1: data latch.
    - O_word=shreg, O_word_idx=word_cnt, O_scan_idx=encode(scan), pulse O_word_valid.
    - word_cnt increments, saturating at 255.
    - If bit_cnt!=16, set O_err_bitcnt.
    - If scan is not one-hot, set O_err_scan and report O_scan_idx=0.
  - le_cnt 2..3: vsync.
    - Pulse O_frame_start, word_cnt<=0.
    - O_gclk_cnt<=gclk_acc; gclk_acc<=0.
  - le_cnt>=4: config write. O_cfg_word=shreg, pulse O_cfg_valid.
  - le_cnt==0 (LE pulse with no DCLK edge): ignored, no output.
  - After any LE falling edge, bit_cnt<=0 and le_cnt<=0.
- gclk_acc (16 bits) increments on each GCLK rising edge and saturates at 0xFFFF.
- If a GCLK edge and a vsync occur in the same cycle, that edge counts into the new frame: gclk_acc<=1.
- If a DCLK rising edge and an LE falling edge occur in the same cycle, the shift and count happen first, then the command is decoded from the updated values.
- Error flags clear only on I_rst.
- State machine IDLE/SHIFT/LATCH:
  - IDLE → SHIFT on the first DCLK rise.
  - SHIFT → LATCH on an LE fall.
  - LATCH → IDLE after one cycle (the outputs are registered in LATCH).

## Timing
- Reset values:
  - All outputs 0, including the sticky flags, O_gclk_cnt and O_word_idx.
  - Internal counters, shift register and synchronisers 0. The FSM is in IDLE.
- Latency: LE sampled low by I_clk at edge N → the output pulse is high during cycle N+3 only.
- Input constraints:
  - DCLK high and low each ≥2 I_clk periods (≤12.5 MHz).
  - GCLK same limit.
  - LE must be stable ≥2 I_clk periods around DCLK edges.
  - Inputs outside these limits give undefined decode but never lock up.
- I_rst asserted mid-word: all state is cleared on the next edge, and no pulse is emitted for the partial command.
- Output pulses never overlap, because at most one LE fall can be in LATCH at a time.

## Test plan
- Reset: hold I_rst for 4 cycles → all outputs 0. FSM in IDLE.
- Data latch: shift 0xA5C3 MSB first at 1 MHz DCLK, LE high for the last DCLK, scan=4'b0010 → O_word_valid pulse, O_word=0xA5C3, O_word_idx=0, O_scan_idx=1, no error flags.
- Frame of six words, then a vsync:
  - Send words 0x0001..0x0006, then a vsync (LE high for 3 DCLKs).
  - Expect indices 0..5 and one O_frame_start pulse.
  - With 1000 GCLK edges during the frame, O_gclk_cnt=1000.
- Config: 16 bits 0x1234 with LE high for 5 DCLKs → O_cfg_valid pulse with O_cfg_word=0x1234. No O_word_valid pulse.
- Bit-count error: data latch after 15 bits → O_word_valid still pulses and O_err_bitcnt=1 and stays 1. A later clean word does not clear it.
- Scan error and mid-word reset:
  - Data latch with scan=4'b0110 → O_err_scan=1, O_scan_idx=0.
  - Pulse I_rst after 8 bits of the next word → no pulse, all flags 0.
  - A following clean word decodes with bit_cnt=16.
